bsg_downstream_in: RTL and testbench

- Receive end of the two-channel, token-flow-controlled link that the upstream output block drives.
- Each 64-bit word arrives as 4 beats of 2 bytes, one byte per channel per beat. The block reassembles the word, buffers it in a FIFO and presents it to the core with a valid/yumi handshake.
- Returns one io_token pulse to the upstream sender per word the core consumes, which replenishes the sender's credit window.

---
 rtl/bsg_downstream_in.sv | 145 ++++++++++++++
 tb/tb_bsg_downstream_in.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_downstream_in.sv
// Receive side of the two-channel token link: reassembles 4-beat words into a FIFO for the core
// and returns one token per consumed word. BSG_DOWNSTREAM_IN_OVF_CHK_EN adds overflow_err.
module bsg_downstream_in #(
    parameter int unsigned CH_WIDTH   = 8,
    parameter int unsigned WORD_WIDTH = 8 * CH_WIDTH,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_valid_in,
    input  logic [CH_WIDTH-1:0]   io_data_in_ch0,
    input  logic [CH_WIDTH-1:0]   io_data_in_ch1,
    output logic                  io_token,
    output logic                  core_valid_out,
    output logic [WORD_WIDTH-1:0] core_data_out,
    input  logic                  core_yumi_in,
    output logic [PTR_W:0]        fifo_count
`ifdef BSG_DOWNSTREAM_IN_OVF_CHK_EN
    ,
    output logic                  overflow_err
`endif
);

    localparam logic [PTR_W-1:0] PtrOne  = 1;
    localparam logic [PTR_W:0]   CntOne  = 1;
    localparam logic [PTR_W:0]   CntFull = (PTR_W+1)'(FIFO_DEPTH);

    logic [1:0]            step_q, step_d;
    logic [WORD_WIDTH-1:0] part_q, part_d;
    logic [WORD_WIDTH-1:0] word_merged;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  token_q;
    logic                  word_done, full, deq, wr_en;
    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];

    // Lane placement: ch0 fills bytes 0,1,4,5 and ch1 fills bytes 2,3,6,7 across steps 0..3.
    always_comb begin
        word_merged = part_q;
        case (step_q)
            2'd0: begin
                word_merged[0*CH_WIDTH +: CH_WIDTH] = io_data_in_ch0;
                word_merged[2*CH_WIDTH +: CH_WIDTH] = io_data_in_ch1;
            end
            2'd1: begin
                word_merged[1*CH_WIDTH +: CH_WIDTH] = io_data_in_ch0;
                word_merged[3*CH_WIDTH +: CH_WIDTH] = io_data_in_ch1;
            end
            2'd2: begin
                word_merged[4*CH_WIDTH +: CH_WIDTH] = io_data_in_ch0;
                word_merged[6*CH_WIDTH +: CH_WIDTH] = io_data_in_ch1;
            end
            default: begin
                word_merged[5*CH_WIDTH +: CH_WIDTH] = io_data_in_ch0;
                word_merged[7*CH_WIDTH +: CH_WIDTH] = io_data_in_ch1;
            end
        endcase
    end

    assign word_done = io_valid_in && (step_q == 2'd3);
    assign full      = (count_q == CntFull);
    assign deq       = core_yumi_in && (count_q != '0);
    // A dequeue in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign wr_en     = word_done && (!full || deq);

    always_comb begin
        step_d   = step_q;
        part_d   = part_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (io_valid_in) begin
            step_d = step_q + 2'd1;
            part_d = word_merged;
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case ({wr_en, deq})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            step_q   <= 2'd0;
            part_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            token_q  <= 1'b0;
        end else begin
            step_q   <= step_d;
            part_q   <= part_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            token_q  <= deq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_ptr_q] <= word_merged;
        end
    end

    assign io_token       = token_q;
    assign core_valid_out = (count_q != '0);
    assign core_data_out  = mem[rd_ptr_q];
    assign fifo_count     = count_q;

`ifdef BSG_DOWNSTREAM_IN_OVF_CHK_EN
    logic overflow;
    logic ovf_q;

    assign overflow = word_done && full && !deq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (overflow) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow_err = ovf_q;

    always @(posedge clk) begin
        if (rst) begin
            assert (!overflow) else $warning("bsg_downstream_in: word dropped, FIFO full");
            assert (!(core_yumi_in && (count_q == '0)))
                else $warning("bsg_downstream_in: yumi while empty");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_downstream_in.sv
// Self-checking bench for bsg_downstream_in: vector table plus scoreboarded corner sequences.
module tb_bsg_downstream_in;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_valid_in;
    logic [7:0]  io_data_in_ch0;
    logic [7:0]  io_data_in_ch1;
    logic        io_token;
    logic        core_valid_out;
    logic [63:0] core_data_out;
    logic        core_yumi_in;
    logic [6:0]  fifo_count;
`ifdef BSG_DOWNSTREAM_IN_OVF_CHK_EN
    logic        overflow_err;
`endif

    bsg_downstream_in dut (
        .clk            (clk),
        .rst            (rst),
        .io_valid_in    (io_valid_in),
        .io_data_in_ch0 (io_data_in_ch0),
        .io_data_in_ch1 (io_data_in_ch1),
        .io_token       (io_token),
        .core_valid_out (core_valid_out),
        .core_data_out  (core_data_out),
        .core_yumi_in   (core_yumi_in),
        .fifo_count     (fifo_count)
`ifdef BSG_DOWNSTREAM_IN_OVF_CHK_EN
        ,
        .overflow_err   (overflow_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [63:0] word;
        int          gap;
        logic [63:0] exp_data;
        logic [6:0]  exp_count;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic beat(input logic [7:0] c0, input logic [7:0] c1);
        io_valid_in    = 1'b1;
        io_data_in_ch0 = c0;
        io_data_in_ch1 = c1;
        tick();
        io_valid_in    = 1'b0;
        io_data_in_ch0 = 8'h00;
        io_data_in_ch1 = 8'h00;
    endtask

    // Beat bytes derived from word = {hi, lo}; idle gap cycles inserted after beats 0..2.
    task automatic send_word(input logic [63:0] w, input int gap, input bit chk_gap);
        logic [31:0] lo, hi;
        lo = w[31:0];
        hi = w[63:32];
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: beat(lo[7:0],  lo[23:16]);
                1: beat(lo[15:8], lo[31:24]);
                2: beat(hi[7:0],  hi[23:16]);
                default: beat(hi[15:8], hi[31:24]);
            endcase
            if (s < 3) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                end
                if (chk_gap) check("no_early_valid", 64'(core_valid_out), 64'd0);
            end
        end
    endtask

    // Continuous yumi; each cycle the head must match the scoreboard, then a token follows.
    task automatic drain(input int n);
        logic [63:0] e;
        core_yumi_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                check("drain_sb_empty", 64'd1, 64'd0);
                e = '0;
            end else begin
                e = exp_q.pop_front();
            end
            check("drain_valid", 64'(core_valid_out), 64'd1);
            check("drain_data", core_data_out, e);
            tick();
            check("drain_token", 64'(io_token), 64'd1);
        end
        core_yumi_in = 1'b0;
        tick();
        check("drain_token_off", 64'(io_token), 64'd0);
    endtask

    task automatic fill(input int n);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom(), $urandom()};
            send_word(w, 0, 1'b0);
            exp_q.push_back(w);
        end
    endtask

    initial begin
        logic [63:0] w;
        rst            = 1'b0;
        io_valid_in    = 1'b0;
        io_data_in_ch0 = 8'h00;
        io_data_in_ch1 = 8'h00;
        core_yumi_in   = 1'b0;

        vecs[0] = '{64'h0123456789ABCDEF, 0, 64'h0123456789ABCDEF, 7'd1};
        vecs[1] = '{64'h0123456789ABCDEF, 3, 64'h0123456789ABCDEF, 7'd1};
        vecs[2] = '{64'hFFFF0000AAAA5555, 1, 64'hFFFF0000AAAA5555, 7'd1};
        vecs[3] = '{64'h0000000000000000, 2, 64'h0000000000000000, 7'd1};
        vecs[4] = '{64'h8001_7E02_C003_3C04, 0, 64'h8001_7E02_C003_3C04, 7'd1};

        tick();
        tick();
        check("rst_valid", 64'(core_valid_out), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_token", 64'(io_token), 64'd0);
`ifdef BSG_DOWNSTREAM_IN_OVF_CHK_EN
        check("rst_ovf", 64'(overflow_err), 64'd0);
`endif
        rst = 1'b1;
        tick();

        // Single words, with and without gaps, each consumed by one yumi.
        for (int v = 0; v < 5; v++) begin
            send_word(vecs[v].word, vecs[v].gap, 1'b1);
            exp_q.push_back(vecs[v].exp_data);
            check("vec_valid", 64'(core_valid_out), 64'd1);
            check("vec_data", core_data_out, vecs[v].exp_data);
            check("vec_count", 64'(fifo_count), 64'(vecs[v].exp_count));
            check("vec_token_idle", 64'(io_token), 64'd0);
            drain(1);
            check("vec_empty", 64'(core_valid_out), 64'd0);
            check("vec_count0", 64'(fifo_count), 64'd0);
        end

        // Yumi while empty is ignored.
        core_yumi_in = 1'b1;
        tick();
        core_yumi_in = 1'b0;
        tick();
        check("empty_yumi_token", 64'(io_token), 64'd0);
        check("empty_yumi_count", 64'(fifo_count), 64'd0);

        // Fill to full, then drain in order with back-to-back tokens.
        fill(64);
        check("full_count", 64'(fifo_count), 64'd64);
        drain(64);
        check("full_drained", 64'(fifo_count), 64'd0);

        // Full plus simultaneous complete and dequeue.
        fill(64);
        w = 64'hDEAD_BEEF_0BAD_F00D;
        beat(w[7:0],   w[23:16]);
        beat(w[15:8],  w[31:24]);
        beat(w[39:32], w[55:48]);
        core_yumi_in = 1'b1;
        check("simul_head", core_data_out, exp_q.pop_front());
        beat(w[47:40], w[63:56]);
        core_yumi_in = 1'b0;
        exp_q.push_back(w);
        check("simul_count", 64'(fifo_count), 64'd64);
        check("simul_token", 64'(io_token), 64'd1);
`ifdef BSG_DOWNSTREAM_IN_OVF_CHK_EN
        check("simul_ovf", 64'(overflow_err), 64'd0);
`endif
        drain(64);

        // Overflow: word 65 dropped, step realigns for the following word.
        fill(64);
        send_word(64'h5A5A_5A5A_A5A5_A5A5, 0, 1'b0);
        check("ovf_count", 64'(fifo_count), 64'd64);
`ifdef BSG_DOWNSTREAM_IN_OVF_CHK_EN
        check("ovf_err", 64'(overflow_err), 64'd1);
`endif
        drain(2);
        w = 64'h1122_3344_5566_7788;
        send_word(w, 0, 1'b0);
        exp_q.push_back(w);
        check("ovf_after_count", 64'(fifo_count), 64'd63);
        drain(63);

        // Reset mid-word discards the partial word.
        beat(8'h11, 8'h22);
        beat(8'h33, 8'h44);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_token", 64'(io_token), 64'd0);
        check("midrst_count", 64'(fifo_count), 64'd0);
        check("midrst_valid", 64'(core_valid_out), 64'd0);
        send_word(64'hFFFF0000AAAA5555, 0, 1'b1);
        exp_q.push_back(64'hFFFF0000AAAA5555);
        check("midrst_data", core_data_out, 64'hFFFF0000AAAA5555);
        check("midrst_word_count", 64'(fifo_count), 64'd1);
        drain(1);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
